// File: rtl/mem_system_nway.sv
// N-way set-associative write-back/write-allocate cache controller with a four-bank backing memory.
// Ways and memory are held as internal arrays; memory reads return two cycles after issue.
module mem_system_nway #(
  parameter int memtype = 0,
  parameter int WAYS    = 2,
  parameter int RR_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmpRd  = 3'd1,
    StCmpWr  = 3'd2,
    StWb     = 3'd3,
    StFill   = 3'd4,
    StFinish = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [15:0]     addr_q, addr_d, din_q, din_d;
  logic            wr_op_q, wr_op_d;
  logic [RR_W-1:0] rr_q, rr_d, victim_q, victim_d;
  logic [2:0]      iss_q, iss_d, ret_q, ret_d;

  logic [4:0] tag;
  logic [7:0] idx;
  logic [1:0] word;
  assign tag  = addr_q[15:11];
  assign idx  = addr_q[10:3];
  assign word = addr_q[2:1];

  // Way storage
  logic [15:0]  data_q  [WAYS][256][4];
  logic [4:0]   tag_q   [WAYS][256];
  logic [255:0] valid_q [WAYS];
  logic [255:0] dirty_q [WAYS];

  // Backing memory: four banks on word address bits [2:1]
  logic [15:0] mem_q  [32768];
  logic [2:0]  busy_q [4];
  logic [1:0]  rp_v_q;
  logic [15:0] rp_d0_q, rp_d1_q;

  logic        mem_rd, mem_wr, mem_stall, mem_acc;
  logic [15:0] mem_addr, mem_wdata;

  logic            wr_en, wr_dirty;
  logic [RR_W-1:0] wr_way;
  logic [1:0]      wr_word;
  logic [15:0]     wr_data;

  logic [WAYS-1:0] hit_vec, inv_vec;
  logic [RR_W-1:0] hit_way, inv_way;
  logic            hit_any, inv_any, multi_hit, rdwr_err, dbl_err;

  // A bank stays busy for four cycles after any accepted access.
  assign mem_stall = (mem_rd | mem_wr) && (busy_q[mem_addr[2:1]] != 3'd0);
  assign mem_acc   = (mem_rd | mem_wr) && !mem_stall;

  always_comb begin
    hit_vec   = '0;
    inv_vec   = '0;
    hit_way   = '0;
    inv_way   = '0;
    hit_any   = 1'b0;
    inv_any   = 1'b0;
    multi_hit = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      hit_vec[k] = valid_q[k][idx] && (tag_q[k][idx] == tag);
      inv_vec[k] = !valid_q[k][idx];
      if (hit_vec[k]) begin
        if (hit_any) multi_hit = 1'b1;
        else         hit_way   = RR_W'(k);
        hit_any = 1'b1;
      end
      if (inv_vec[k] && !inv_any) begin
        inv_way = RR_W'(k);
        inv_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_op_d   = wr_op_q;
    rr_d      = rr_q;
    victim_d  = victim_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    DataOut   = 16'h0000;
    Done      = 1'b0;
    Stall     = 1'b1;
    CacheHit  = 1'b0;
    rdwr_err  = 1'b0;
    dbl_err   = 1'b0;
    wr_en     = 1'b0;
    wr_way    = victim_q;
    wr_word   = word;
    wr_data   = din_q;
    wr_dirty  = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {tag, idx, iss_q[1:0], 1'b0};
    mem_wdata = data_q[victim_q][idx][iss_q[1:0]];
    case (state_q)
      StIdle: begin
        Stall   = 1'b0;
        addr_d  = Addr;
        din_d   = DataIn;
        iss_d   = 3'd0;
        ret_d   = 3'd0;
        if (Rd && Wr) begin
          rdwr_err = 1'b1;
        end else if (Rd) begin
          state_d = StCmpRd;
          wr_op_d = 1'b0;
        end else if (Wr) begin
          state_d = StCmpWr;
          wr_op_d = 1'b1;
        end
      end
      StCmpRd, StCmpWr: begin
        dbl_err = multi_hit;
        if (hit_any) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          state_d  = StIdle;
          if (state_q == StCmpRd) begin
            DataOut = data_q[hit_way][idx][word];
          end else begin
            wr_en  = 1'b1;
            wr_way = hit_way;
          end
        end else begin
          iss_d = 3'd0;
          ret_d = 3'd0;
          if (inv_any) begin
            victim_d = inv_way;
            state_d  = StFill;
          end else begin
            victim_d = rr_q;
            rr_d     = (rr_q == RR_W'(WAYS - 1)) ? '0 : rr_q + RR_W'(1);
            state_d  = dirty_q[rr_q][idx] ? StWb : StFill;
          end
        end
      end
      StWb: begin
        mem_wr   = 1'b1;
        mem_addr = {tag_q[victim_q][idx], idx, iss_q[1:0], 1'b0};
        if (!mem_stall) begin
          iss_d = iss_q + 3'd1;
          if (iss_q[1:0] == 2'd3) begin
            state_d = StFill;
            iss_d   = 3'd0;
          end
        end
      end
      StFill: begin
        if (!iss_q[2]) begin
          mem_rd = 1'b1;
          if (!mem_stall) iss_d = iss_q + 3'd1;
        end
        if (rp_v_q[1]) begin
          wr_en    = 1'b1;
          wr_word  = ret_q[1:0];
          wr_data  = rp_d1_q;
          wr_dirty = 1'b0;
          ret_d    = ret_q + 3'd1;
          if (ret_q[1:0] == 2'd3) state_d = StFinish;
        end
      end
      StFinish: begin
        Done    = 1'b1;
        state_d = StIdle;
        if (wr_op_q) wr_en   = 1'b1;
        else         DataOut = data_q[victim_q][idx][word];
      end
      default: state_d = StIdle;
    endcase
  end

  assign err = rdwr_err | dbl_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= 16'h0000;
      din_q    <= 16'h0000;
      wr_op_q  <= 1'b0;
      rr_q     <= '0;
      victim_q <= '0;
      iss_q    <= 3'd0;
      ret_q    <= 3'd0;
      rp_v_q   <= 2'b00;
      for (int k = 0; k < WAYS; k++) begin
        valid_q[k] <= '0;
        dirty_q[k] <= '0;
      end
      for (int b = 0; b < 4; b++) busy_q[b] <= 3'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wr_op_q  <= wr_op_d;
      rr_q     <= rr_d;
      victim_q <= victim_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      rp_v_q   <= {rp_v_q[0], mem_acc & mem_rd};
      if (wr_en) begin
        valid_q[wr_way][idx] <= 1'b1;
        dirty_q[wr_way][idx] <= wr_dirty;
      end
      for (int b = 0; b < 4; b++) begin
        if (mem_acc && (mem_addr[2:1] == 2'(b))) busy_q[b] <= 3'd4;
        else if (busy_q[b] != 3'd0)              busy_q[b] <= busy_q[b] - 3'd1;
      end
    end
  end

  // Array contents carry no reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      data_q[wr_way][idx][wr_word] <= wr_data;
      tag_q[wr_way][idx]           <= tag;
    end
    if (mem_acc && mem_wr && !rst) mem_q[mem_addr[15:1]] <= mem_wdata;
    rp_d0_q <= mem_q[mem_addr[15:1]];
    rp_d1_q <= rp_d0_q;
  end

  // Arrays here have no dump facility; these inputs/bits carry no function.
  logic unused_bits;
  assign unused_bits = ^{createdump, addr_q[0], mem_addr[0], ret_q[2], 1'(memtype)};

endmodule
